// File: rtl/ex_forward_ctrl.sv
// EX-stage forwarding select generator with load-use stall detection.
// Tracks in-flight destination registers and registers the 3:1 operand
// mux selects so they line up with the instruction entering EX.
module ex_forward_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rt,
  input  logic [REG_W-1:0] i_dest,
  input  logic             i_reg_write,
  input  logic             i_mem_read,
  input  logic             i_flush,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_stall,
  output logic [CNT_W-1:0] o_stall_count
);

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // EX slot: instruction currently in EX.
  logic             ex_valid;
  logic [REG_W-1:0] ex_dest;
  logic             ex_rw;
  logic             ex_mr;

  // MEM slot. Its load flag and the whole WB slot are not tracked: selects are
  // computed one stage ahead, so only EX (next MEM) and MEM (next WB) ever
  // decide a forward, and only the EX load flag gates anything.
  logic             mem_valid;
  logic [REG_W-1:0] mem_dest;
  logic             mem_rw;

  logic     load_ex;
  fwd_sel_t fwd_a_next;
  fwd_sel_t fwd_b_next;

  function automatic fwd_sel_t select_for(input logic [REG_W-1:0] r,
                                          input logic             ex_v,
                                          input logic [REG_W-1:0] ex_d,
                                          input logic             ex_w,
                                          input logic             ex_m,
                                          input logic             mem_v,
                                          input logic [REG_W-1:0] mem_d,
                                          input logic             mem_w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ex_v && ex_w && (ex_d != '0) && (ex_d == r) && !ex_m)
      sel = FWD_MEM;
    else if (mem_v && mem_w && (mem_d != '0) && (mem_d == r))
      sel = FWD_WB;
    return sel;
  endfunction

  // Load-use hazard against the load sitting in EX; rt compared unconditionally.
  always_comb begin
    o_stall = i_valid && !i_flush && ex_valid && ex_mr && ex_rw &&
              (ex_dest != '0) && ((ex_dest == i_rs) || (ex_dest == i_rt));
    load_ex = i_valid && !i_flush && !o_stall;
  end

  // Next-cycle operand selects; a bubble entering EX gets regfile selects.
  always_comb begin
    fwd_a_next = FWD_RF;
    fwd_b_next = FWD_RF;
    if (load_ex) begin
      fwd_a_next = select_for(i_rs, ex_valid, ex_dest, ex_rw, ex_mr,
                              mem_valid, mem_dest, mem_rw);
      fwd_b_next = select_for(i_rt, ex_valid, ex_dest, ex_rw, ex_mr,
                              mem_valid, mem_dest, mem_rw);
    end
  end

  // Pipeline occupancy tracking and registered selects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_dest   <= '0;
      ex_rw     <= 1'b0;
      ex_mr     <= 1'b0;
      mem_valid <= 1'b0;
      mem_dest  <= '0;
      mem_rw    <= 1'b0;
      o_fwd_a   <= FWD_RF;
      o_fwd_b   <= FWD_RF;
    end else begin
      mem_valid <= ex_valid;
      mem_dest  <= ex_dest;
      mem_rw    <= ex_rw;
      ex_valid  <= load_ex;
      ex_dest   <= i_dest;
      ex_rw     <= i_reg_write;
      ex_mr     <= i_mem_read;
      o_fwd_a   <= fwd_a_next;
      o_fwd_b   <= fwd_b_next;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      o_stall_count <= '0;
    else if (o_stall && (o_stall_count != '1))
      o_stall_count <= o_stall_count + 1'b1;
  end

endmodule
